// File: rtl/border_pad_pkg.sv
// Shared helpers for the border padding path: border split per kernel size and
// full-frame coordinate widths/types.
package border_pad_pkg;

  localparam int DEFAULT_IMAGE_HEIGHT = 32'sd768;
  localparam int DEFAULT_IMAGE_WIDTH  = 32'sd1024;
  localparam int DEFAULT_KERNEL_SIZE  = 32'sd3;

  // Rows/columns lost before the first interior item (top/left side).
  function automatic int border_lo(input int kernel_size);
    return (kernel_size - 32'sd1) / 32'sd2;
  endfunction

  // Rows/columns lost after the last interior item; even kernels put the extra one here.
  function automatic int border_hi(input int kernel_size);
    return (kernel_size - 32'sd1) - border_lo(kernel_size);
  endfunction

  function automatic int coord_width(input int extent);
    return (extent > 32'sd1) ? $clog2(extent) : 32'sd1;
  endfunction

  localparam int DEFAULT_ROW_W = coord_width(DEFAULT_IMAGE_HEIGHT);
  localparam int DEFAULT_COL_W = coord_width(DEFAULT_IMAGE_WIDTH);

  typedef logic [DEFAULT_ROW_W-1:0] frame_row_t;
  typedef logic [DEFAULT_COL_W-1:0] frame_col_t;

endpackage

// File: rtl/border_pad_raster_counter.sv
// raster_counter: row/column walker over a HEIGHT x WIDTH raster with wrap to
// (0,0) after the last position; is_last_o flags the final position of a frame.
module raster_counter
  import border_pad_pkg::*;
#(
  parameter int HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int ROW_W  = coord_width(HEIGHT),
  parameter int COL_W  = coord_width(WIDTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             advance_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             is_last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             last_row_s, last_col_s;

  assign last_row_s = (row_q == ROW_W'(HEIGHT - 32'sd1));
  assign last_col_s = (col_q == COL_W'(WIDTH - 32'sd1));

  // Next position: step column, roll into the next row, wrap at end of frame.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (advance_i) begin
      if (last_col_s) begin
        col_d = '0;
        if (last_row_s) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Position state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign is_last_o = last_row_s && last_col_s;

endmodule

// File: rtl/border_pad.sv
// border_pad: re-inflates a shrunken kernel result stream to full frame geometry
// by emitting PAD_VALUE at border positions. Optional BORDER_PAD_COORD_CHECK_EN
// adds a sticky coord_error_o for mis-tagged input beats.
module border_pad
  import border_pad_pkg::*;
#(
  parameter int                   ITEM_BITS    = 32'sd8,
  parameter int                   KERNEL_SIZE  = DEFAULT_KERNEL_SIZE,
  parameter int                   IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int                   IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter logic [ITEM_BITS-1:0] PAD_VALUE    = '0,
  localparam int                  ROW_W        = coord_width(IMAGE_HEIGHT),
  localparam int                  COL_W        = coord_width(IMAGE_WIDTH)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  // slave side: interior results in raster order
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [ITEM_BITS-1:0] in_data_i,
  input  logic [ROW_W-1:0]     in_row_i,
  input  logic [COL_W-1:0]     in_col_i,
  // master side: padded full frame in raster order
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ITEM_BITS-1:0] out_data_o,
  output logic [ROW_W-1:0]     out_row_o,
  output logic [COL_W-1:0]     out_col_o
`ifdef BORDER_PAD_COORD_CHECK_EN
  ,
  output logic                 coord_error_o
`endif
);

  localparam int TOP    = border_lo(KERNEL_SIZE);
  localparam int LEFT   = border_lo(KERNEL_SIZE);
  localparam int BOTTOM = border_hi(KERNEL_SIZE);
  localparam int RIGHT  = border_hi(KERNEL_SIZE);
  localparam int INT_H  = IMAGE_HEIGHT - TOP - BOTTOM;
  localparam int INT_W  = IMAGE_WIDTH - LEFT - RIGHT;

  logic [ROW_W-1:0]     pos_row_s, rel_row_s;
  logic [COL_W-1:0]     pos_col_s, rel_col_s;
  logic                 interior_s, can_load_s, advance_s, frame_last_unused_s;
  logic                 valid_q, valid_d;
  logic [ITEM_BITS-1:0] data_q, data_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;

  raster_counter #(
    .HEIGHT (IMAGE_HEIGHT),
    .WIDTH  (IMAGE_WIDTH),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_pos (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .advance_i (advance_s),
    .row_o     (pos_row_s),
    .col_o     (pos_col_s),
    .is_last_o (frame_last_unused_s)
  );

  // Offsetting by TOP/LEFT makes positions above/left of the interior wrap high,
  // so one unsigned compare per axis covers both bounds.
  assign rel_row_s  = pos_row_s - ROW_W'(TOP);
  assign rel_col_s  = pos_col_s - COL_W'(LEFT);
  assign interior_s = ({1'b0, rel_row_s} < (ROW_W + 1)'(INT_H)) &&
                      ({1'b0, rel_col_s} < (COL_W + 1)'(INT_W));

  assign can_load_s = !valid_q || out_ready_i;
  assign in_ready_o = can_load_s && interior_s && !reset_i;
  assign advance_s  = can_load_s && (!interior_s || in_valid_i) && !reset_i;

  // Output register load: pad beat, forwarded interior beat, or bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    row_d   = row_q;
    col_d   = col_q;
    if (can_load_s) begin
      valid_d = advance_s;
      data_d  = interior_s ? in_data_i : PAD_VALUE;
      row_d   = pos_row_s;
      col_d   = pos_col_s;
    end else begin
      valid_d = valid_q;
    end
  end

  // Master output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;

`ifdef BORDER_PAD_COORD_CHECK_EN
  logic coord_err_q, coord_err_d;

  always_comb begin
    coord_err_d = coord_err_q;
    if (in_valid_i && in_ready_o &&
        ((in_row_i != rel_row_s) || (in_col_i != rel_col_s))) begin
      coord_err_d = 1'b1;
    end else begin
      coord_err_d = coord_err_q;
    end
  end

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      coord_err_q <= 1'b0;
    end else begin
      coord_err_q <= coord_err_d;
    end
  end

  assign coord_error_o = coord_err_q;
`else
  logic coord_unused_s;
  assign coord_unused_s = ^{in_row_i, in_col_i};
`endif

endmodule

// File: tb/tb_border_pad.sv
// Directed bench for border_pad: 4x5 frame with 3x3 kernel, plus a 5x5 frame
// with a 4x4 kernel; covers the BORDER_PAD_COORD_CHECK_EN build when defined.
module tb_border_pad;

  localparam int IH = 4;
  localparam int IW = 5;
  localparam int FRAME = IH * IW;
  localparam logic [7:0] PADV = 8'hEE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_row = 2'd0;
  logic [2:0] in_col = 3'd0;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] out_data;
  logic [1:0] out_row;
  logic [2:0] out_col;

  logic       rst4 = 1'b1;
  logic       in_valid4 = 1'b0, in_ready4;
  logic [7:0] in_data4 = 8'h00;
  logic [2:0] in_row4 = 3'd0, in_col4 = 3'd0;
  logic       out_valid4, out_ready4 = 1'b1;
  logic [7:0] out_data4;
  logic [2:0] out_row4, out_col4;

`ifdef BORDER_PAD_COORD_CHECK_EN
  logic coord_err, coord_err4;
`endif

  int n_vec = 0, n_miss = 0;
  int m_pos = 0, beats = 0, idx = 0, bad_idx = -1;
  bit m_valid = 1'b0, m_err = 1'b0;

  always #5 clk = ~clk;

  border_pad #(.ITEM_BITS(8), .KERNEL_SIZE(3), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
               .PAD_VALUE(PADV)) dut (
    .clock_i(clk), .reset_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_row_i(in_row), .in_col_i(in_col),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_row_o(out_row), .out_col_o(out_col)
`ifdef BORDER_PAD_COORD_CHECK_EN
    , .coord_error_o(coord_err)
`endif
  );

  border_pad #(.ITEM_BITS(8), .KERNEL_SIZE(4), .IMAGE_HEIGHT(5), .IMAGE_WIDTH(5),
               .PAD_VALUE(PADV)) dut4 (
    .clock_i(clk), .reset_i(rst4),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_data_i(in_data4),
    .in_row_i(in_row4), .in_col_i(in_col4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4), .out_data_o(out_data4),
    .out_row_o(out_row4), .out_col_o(out_col4)
`ifdef BORDER_PAD_COORD_CHECK_EN
    , .coord_error_o(coord_err4)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_int(input int pos);
    int r, c;
    r = pos / IW;
    c = pos % IW;
    return (r >= 1) && (r < IH - 1) && (c >= 1) && (c < IW - 1);
  endfunction

  function automatic logic [7:0] exp_data(input int pos);
    int r, c;
    r = pos / IW;
    c = pos % IW;
    return is_int(pos) ? 8'((r - 1) * 3 + (c - 1) + 1) : PADV;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_valid = 1'b0; m_err = 1'b0; beats = 0; idx = 0;
  endtask

  // Called just after a posedge: present this cycle's inputs.
  task automatic drive_inputs(input int mode);
    int v;
    v = idx % 6;
    in_data = 8'(v + 1);
    in_row  = 2'(v / 3);
    in_col  = (idx == bad_idx) ? 3'd2 : 3'(v % 3);
    if (mode == 0) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
    end else begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ~out_ready;
    end
  endtask

  // Called at negedge: compare against the model, then advance it over the coming edge.
  task automatic cycle_check();
    bit can, intr;
    int p;
    can  = !m_valid || out_ready;
    intr = is_int(m_pos);
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    check_val("in_ready", 32'(in_ready), 32'(can && intr));
`ifdef BORDER_PAD_COORD_CHECK_EN
    check_val("coord_error", 32'(coord_err), 32'(m_err));
`endif
    if (out_valid && out_ready) begin
      p = beats % FRAME;
      check_val("beat_data", 32'(out_data), 32'(exp_data(p)));
      check_val("beat_row", 32'(out_row), 32'(p / IW));
      check_val("beat_col", 32'(out_col), 32'(p % IW));
      beats++;
    end
    if (in_valid && in_ready) begin
      if (idx == bad_idx) m_err = 1'b1;
      idx++;
    end
    if (can) begin
      if (!intr || in_valid) begin
        m_valid = 1'b1;
        m_pos = (m_pos + 1) % FRAME;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic run(input int mode, input int n);
    int target, cyc;
    target = beats + n;
    cyc = 0;
    while (beats < target && cyc < 400) begin
      drive_inputs(mode);
      @(negedge clk);
      cycle_check();
      @(posedge clk); #1;
      cyc++;
    end
    check_val("run_beats", 32'(beats), 32'(target));
  endtask

  // One reset cycle with upstream still offering data; checks cleared outputs.
  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_data", 32'(out_data), 32'd0);
    check_val("rst_row", 32'(out_row), 32'd0);
    check_val("rst_col", 32'(out_col), 32'd0);
`ifdef BORDER_PAD_COORD_CHECK_EN
    check_val("rst_coord_error", 32'(coord_err), 32'd0);
`endif
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int b4, idx4, r, c;
    // Even kernel: TOP=LEFT=1, BOTTOM=RIGHT=2, interior (1..2,1..2).
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1; in_data4 = 8'd1;
    b4 = 0; idx4 = 0;
    for (int cyc = 0; cyc < 100 && b4 < 25; cyc++) begin
      @(negedge clk);
      if (out_valid4) begin
        r = b4 / 5;
        c = b4 % 5;
        check_val("k4_data", 32'(out_data4),
                  (r >= 1 && r <= 2 && c >= 1 && c <= 2) ? 32'((r - 1) * 2 + c) : 32'(PADV));
        check_val("k4_row", 32'(out_row4), 32'(r));
        check_val("k4_col", 32'(out_col4), 32'(c));
        b4++;
      end
      if (in_ready4) idx4++;
      @(posedge clk); #1;
      in_data4 = 8'(idx4 + 1);
    end
    check_val("k4_beats", 32'(b4), 32'd25);
    check_val("k4_inputs", 32'(idx4), 32'd4);

    pulse_reset();
    run(0, 2 * FRAME);
    run(1, FRAME);
    run(0, 9);
    pulse_reset();
    run(0, FRAME);

`ifdef BORDER_PAD_COORD_CHECK_EN
    bad_idx = 1;
    pulse_reset();
    run(0, FRAME);
    check_val("coord_error_sticky", 32'(coord_err), 32'd1);
    bad_idx = -1;
    pulse_reset();
    run(0, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
